// File: rtl/pipe_hazard_ctrl_if.sv
// Status/control bundle between the pipeline datapath and the hazard sequencer.
// The master side is the datapath. The slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs1_ind;
  logic [4:0] id_rs2_ind;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex1_rd_ind;
  logic [4:0] ex2_rd_ind;
  logic       ex1_memread;
  logic       ex2_memread;
  logic       ex2_mispredict;
  logic       dmem_busy;

  logic       pc_en;
  logic       pc_redirect;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex1_flush;
  logic       ex1_ex2_flush;
  logic       back_en;
  logic       stalled;

  modport master (
    output id_rs1_ind, id_rs2_ind, id_uses_rs1, id_uses_rs2,
           ex1_rd_ind, ex2_rd_ind, ex1_memread, ex2_memread,
           ex2_mispredict, dmem_busy,
    input  pc_en, pc_redirect, if_id_en, if_id_flush, id_ex1_flush,
           ex1_ex2_flush, back_en, stalled
  );

  modport slave (
    input  id_rs1_ind, id_rs2_ind, id_uses_rs1, id_uses_rs2,
           ex1_rd_ind, ex2_rd_ind, ex1_memread, ex2_memread,
           ex2_mispredict, dmem_busy,
    output pc_en, pc_redirect, if_id_en, if_id_flush, id_ex1_flush,
           ex1_ex2_flush, back_en, stalled
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the six-stage pipeline. It handles load-use bubbles,
// EX2 mispredict flushes, and the data-memory freeze. It also keeps saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz_if,
  output logic [PERF_W-1:0] o_perf_stall_cnt,
  output logic [PERF_W-1:0] o_perf_flush_cnt
);

  typedef enum logic {RUN, BUBBLE} mode_t;

  mode_t             r_mode;
  mode_t             w_modeNext;
  logic              r_bcnt;
  logic              w_bcntNext;
  logic              w_incStall;
  logic              w_incFlush;
  logic              w_hz1;
  logic              w_hz2;
  logic [PERF_W-1:0] r_stallCnt;
  logic [PERF_W-1:0] r_flushCnt;

  // Load-use hazards. Writes to x0 are never real producers.
  assign w_hz1 = hz_if.ex1_memread && (hz_if.ex1_rd_ind != 5'd0) &&
                 ((hz_if.id_uses_rs1 && (hz_if.id_rs1_ind == hz_if.ex1_rd_ind)) ||
                  (hz_if.id_uses_rs2 && (hz_if.id_rs2_ind == hz_if.ex1_rd_ind)));
  assign w_hz2 = hz_if.ex2_memread && (hz_if.ex2_rd_ind != 5'd0) &&
                 ((hz_if.id_uses_rs1 && (hz_if.id_rs1_ind == hz_if.ex2_rd_ind)) ||
                  (hz_if.id_uses_rs2 && (hz_if.id_rs2_ind == hz_if.ex2_rd_ind)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= RUN;
      r_bcnt <= 1'b0;
    end else begin
      r_mode <= w_modeNext;
      r_bcnt <= w_bcntNext;
    end
  end

  // dmem_busy freezes everything. A pending mispredict stays visible while EX2 is held.
  always_comb begin
    w_modeNext = r_mode;
    w_bcntNext = r_bcnt;
    w_incStall = 1'b0;
    w_incFlush = 1'b0;
    if (!hz_if.dmem_busy) begin
      if (hz_if.ex2_mispredict) begin
        w_modeNext = RUN;
        w_bcntNext = 1'b0;
        w_incFlush = 1'b1;
      end else if (r_mode == BUBBLE) begin
        w_incStall = 1'b1;
        if (r_bcnt) begin
          w_bcntNext = 1'b0;
        end else begin
          w_modeNext = RUN;
        end
      end else if (w_hz1) begin
        w_modeNext = BUBBLE;
        w_bcntNext = 1'b0;
        w_incStall = 1'b1;
      end else if (w_hz2) begin
        w_incStall = 1'b1;
      end
    end
  end

  // The control outputs are Mealy outputs. Reset forces them, so all buffers flush while rst is high.
  always_comb begin
    hz_if.pc_en         = 1'b1;
    hz_if.pc_redirect   = 1'b0;
    hz_if.if_id_en      = 1'b1;
    hz_if.if_id_flush   = 1'b0;
    hz_if.id_ex1_flush  = 1'b0;
    hz_if.ex1_ex2_flush = 1'b0;
    hz_if.back_en       = 1'b1;
    hz_if.stalled       = 1'b0;
    if (rst) begin
      hz_if.pc_en         = 1'b0;
      hz_if.if_id_en      = 1'b0;
      hz_if.back_en       = 1'b0;
      hz_if.if_id_flush   = 1'b1;
      hz_if.id_ex1_flush  = 1'b1;
      hz_if.ex1_ex2_flush = 1'b1;
    end else if (hz_if.dmem_busy) begin
      hz_if.pc_en    = 1'b0;
      hz_if.if_id_en = 1'b0;
      hz_if.back_en  = 1'b0;
      hz_if.stalled  = 1'b1;
    end else if (hz_if.ex2_mispredict) begin
      hz_if.pc_redirect   = 1'b1;
      hz_if.if_id_flush   = 1'b1;
      hz_if.id_ex1_flush  = 1'b1;
      hz_if.ex1_ex2_flush = 1'b1;
    end else if ((r_mode == BUBBLE) || w_hz1 || w_hz2) begin
      hz_if.pc_en        = 1'b0;
      hz_if.if_id_en     = 1'b0;
      hz_if.id_ex1_flush = 1'b1;
      hz_if.stalled      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_incStall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
      if (w_incFlush && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign o_perf_stall_cnt = r_stallCnt;
  assign o_perf_flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. It applies directed vectors and multi-cycle corner sequences.
// It then runs random traffic against a bubble-budget reference model.
module tb_pipe_hazard_ctrl;
  localparam int PERF_W = 4;
  localparam int SAT    = (1 << PERF_W) - 1;

  // Output bit order: pc_en, pc_redirect, if_id_en, if_id_flush, id_ex1_flush, ex1_ex2_flush, back_en, stalled
  localparam logic [7:0] O_RUN    = 8'b1010_0010;
  localparam logic [7:0] O_STALL  = 8'b0000_1011;
  localparam logic [7:0] O_FLUSH  = 8'b1111_1110;
  localparam logic [7:0] O_FREEZE = 8'b0000_0001;
  localparam logic [7:0] O_RESET  = 8'b0001_1100;

  typedef struct packed {
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] ex1Rd;
    logic       ex1Mr;
    logic [4:0] ex2Rd;
    logic       ex2Mr;
    logic       mis;
    logic       busy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [7:0] expOut;
    int         expStall;
    int         expFlush;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PERF_W-1:0] perfStall;
  logic [PERF_W-1:0] perfFlush;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hzIf ();

  pipe_hazard_ctrl #(.PERF_W(PERF_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .hz_if            (hzIf.slave),
    .o_perf_stall_cnt (perfStall),
    .o_perf_flush_cnt (perfFlush)
  );

  function automatic stim_t mkStim(int rs1, int u1, int rs2, int u2, int ex1Rd, int ex1Mr,
                                   int ex2Rd, int ex2Mr, int mis, int busy);
    stim_t s;
    s.rs1 = 5'(rs1);     s.u1 = 1'(u1);
    s.rs2 = 5'(rs2);     s.u2 = 1'(u2);
    s.ex1Rd = 5'(ex1Rd); s.ex1Mr = 1'(ex1Mr);
    s.ex2Rd = 5'(ex2Rd); s.ex2Mr = 1'(ex2Mr);
    s.mis = 1'(mis);     s.busy = 1'(busy);
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    hzIf.id_rs1_ind     = s.rs1;
    hzIf.id_uses_rs1    = s.u1;
    hzIf.id_rs2_ind     = s.rs2;
    hzIf.id_uses_rs2    = s.u2;
    hzIf.ex1_rd_ind     = s.ex1Rd;
    hzIf.ex1_memread    = s.ex1Mr;
    hzIf.ex2_rd_ind     = s.ex2Rd;
    hzIf.ex2_memread    = s.ex2Mr;
    hzIf.ex2_mispredict = s.mis;
    hzIf.dmem_busy      = s.busy;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expOut, input int expStall,
                             input int expFlush);
    logic [7:0] got;
    got = {hzIf.pc_en, hzIf.pc_redirect, hzIf.if_id_en, hzIf.if_id_flush,
           hzIf.id_ex1_flush, hzIf.ex1_ex2_flush, hzIf.back_en, hzIf.stalled};
    checks++;
    if ((got !== expOut) || (perfStall !== PERF_W'(expStall)) || (perfFlush !== PERF_W'(expFlush))) begin
      errors++;
      $display("[TB] FAIL %s: got out=%b stall=%0d flush=%0d, expected out=%b stall=%0d flush=%0d",
               name, got, perfStall, perfFlush, expOut, expStall, expFlush);
    end
  endtask

  // Each cycle starts at a negedge. The clock edge falls between two calls.
  task automatic cycle(input string name, input stim_t s, input logic [7:0] expOut,
                       input int expStall, input int expFlush);
    applyStimulus(s);
    #1;
    checkOutput(name, expOut, expStall, expFlush);
    @(negedge clk);
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    applyStimulus(mkStim(0,0,0,0,0,0,0,0,0,0));
    #1;
    checkOutput(name, O_RESET, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic bit hazard(stim_t s, bit useEx2);
    logic [4:0] rd;
    bit mr;
    rd = useEx2 ? s.ex2Rd : s.ex1Rd;
    mr = useEx2 ? s.ex2Mr : s.ex1Mr;
    return mr && (rd != 0) && ((s.u1 && s.rs1 == rd) || (s.u2 && s.rs2 == rd));
  endfunction

  vec_t tbl[18];
  stim_t idle;
  stim_t rs;
  int bubblesLeft;
  int mStall;
  int mFlush;
  logic [7:0] mOut;

  initial begin
    idle = mkStim(0,0,0,0,0,0,0,0,0,0);
    tbl[0]  = '{idle,                                O_RUN,    0, 0};
    tbl[1]  = '{mkStim(1,1,5,1, 5,1, 0,0, 0,0),      O_STALL,  0, 0};
    tbl[2]  = '{mkStim(1,1,5,1, 0,0, 5,1, 0,0),      O_STALL,  1, 0};
    tbl[3]  = '{mkStim(1,1,5,1, 0,0, 0,0, 0,0),      O_RUN,    2, 0};
    tbl[4]  = '{mkStim(0,1,0,0, 0,1, 0,0, 0,0),      O_RUN,    2, 0};
    tbl[5]  = '{mkStim(7,1,0,0, 0,0, 7,1, 0,0),      O_STALL,  2, 0};
    tbl[6]  = '{idle,                                O_RUN,    3, 0};
    tbl[7]  = '{mkStim(0,0,9,1, 9,1, 0,0, 0,0),      O_STALL,  3, 0};
    tbl[8]  = '{mkStim(0,0,9,1, 0,0, 9,1, 1,0),      O_FLUSH,  4, 0};
    tbl[9]  = '{idle,                                O_RUN,    4, 1};
    tbl[10] = '{mkStim(3,0,0,0, 3,1, 0,0, 0,0),      O_RUN,    4, 1};
    tbl[11] = '{mkStim(3,1,0,0, 3,1, 0,0, 0,1),      O_FREEZE, 4, 1};
    tbl[12] = '{mkStim(3,1,0,0, 3,1, 0,0, 0,0),      O_STALL,  4, 1};
    tbl[13] = '{mkStim(0,0,0,0, 0,0, 0,0, 0,1),      O_FREEZE, 5, 1};
    tbl[14] = '{idle,                                O_STALL,  5, 1};
    tbl[15] = '{idle,                                O_RUN,    6, 1};
    tbl[16] = '{mkStim(2,1,0,0, 0,0, 2,1, 1,0),      O_FLUSH,  6, 1};
    tbl[17] = '{idle,                                O_RUN,    6, 2};

    applyStimulus(idle);
    @(negedge clk);
    doReset("reset_values");

    for (int i = 0; i < 18; i++) begin
      cycle($sformatf("vec%0d", i), tbl[i].s, tbl[i].expOut, tbl[i].expStall, tbl[i].expFlush);
    end

    // A busy memory delays a mispredict that arrives during a bubble. The flush waits until memory is free.
    doReset("reset_busy_seq");
    cycle("busy_hz1", mkStim(4,1,0,0, 4,1, 0,0, 0,0), O_STALL, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("busy_freeze%0d", i), mkStim(4,1,0,0, 0,0, 4,1, 1,1), O_FREEZE, 1, 0);
    end
    cycle("busy_redirect", mkStim(4,1,0,0, 0,0, 4,1, 1,0), O_FLUSH, 1, 0);
    cycle("busy_after", idle, O_RUN, 1, 1);

    // The stall counter saturates at 15 under repeated EX2 load-use stalls.
    doReset("reset_sat_seq");
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("sat_stall%0d", i), mkStim(6,1,0,0, 0,0, 6,1, 0,0), O_STALL,
            (i < SAT) ? i : SAT, 0);
      cycle($sformatf("sat_run%0d", i), idle, O_RUN, (i + 1 < SAT) ? i + 1 : SAT, 0);
    end

    // An asynchronous reset in mid-bubble discards the pending bubble.
    doReset("reset_async_seq");
    applyStimulus(mkStim(8,1,0,0, 8,1, 0,0, 0,0));
    #1;
    checkOutput("async_hz1", O_STALL, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    applyStimulus(idle);
    #1;
    checkOutput("async_rst_out", O_RESET, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle("async_after", idle, O_RUN, 0, 0);

    // Random traffic with a reference model that tracks the number of bubbles still owed.
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 0) begin
        doReset("rand_reset");
        bubblesLeft = 0;
        mStall = 0;
        mFlush = 0;
      end
      rs = mkStim($urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
                  $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,3), $urandom_range(0,1),
                  ($urandom_range(0,7) == 0), ($urandom_range(0,4) == 0));
      if (rs.busy) begin
        mOut = O_FREEZE;
      end else if (rs.mis) begin
        mOut = O_FLUSH;
      end else if (bubblesLeft > 0 || hazard(rs, 1'b0) || hazard(rs, 1'b1)) begin
        mOut = O_STALL;
      end else begin
        mOut = O_RUN;
      end
      applyStimulus(rs);
      #1;
      checkOutput($sformatf("rand%0d", i), mOut, mStall, mFlush);
      if (!rs.busy) begin
        if (rs.mis) begin
          bubblesLeft = 0;
          if (mFlush < SAT) mFlush++;
        end else if (bubblesLeft > 0) begin
          bubblesLeft--;
          if (mStall < SAT) mStall++;
        end else if (hazard(rs, 1'b0)) begin
          bubblesLeft = 1;
          if (mStall < SAT) mStall++;
        end else if (hazard(rs, 1'b1)) begin
          if (mStall < SAT) mStall++;
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
